// File: rtl/serial_mod_checker_ctrl.sv
//============================================================================
// Module   : serial_mod_checker_ctrl
// Purpose  : Accepts a WIDTH-bit word over a valid/ready handshake, feeds it
//            MSB-first through a serial remainder state machine and reports
//            whether the word is divisible by DIVISOR.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            start_valid/ready - word handshake (accept on valid && ready)
//            data_in           - word to check, sampled on the accept edge
//            busy, bit_cnt     - shifting in progress / bits remaining
//            done              - one-cycle result strobe
//            divisible         - registered result (1 = word mod DIVISOR == 0)
//            serial_bit        - bit currently fed to the remainder logic
//            remainder_out     - word mod DIVISOR (only with
//                                SERIAL_MOD_REM_OUT_EN defined)
// Options  : `define SERIAL_MOD_REM_OUT_EN adds the remainder_out port.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module serial_mod_checker_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DIVISOR = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_valid,
    output logic                         start_ready,
    input  logic [WIDTH-1:0]             data_in,
    output logic                         busy,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
    output logic                         done,
    output logic                         divisible,
    output logic                         serial_bit
`ifdef SERIAL_MOD_REM_OUT_EN
    ,
    output logic [$clog2(DIVISOR)-1:0]   remainder_out
`endif
);

    localparam int REM_W = $clog2(DIVISOR);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] c_width   = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [REM_W:0]   c_divisor = (REM_W + 1)'(DIVISOR);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shift;
    logic [REM_W-1:0]   r_rem;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_divisible;
    logic               w_accept;
    logic               w_last_bit;
    logic [REM_W:0]     w_t;
    logic [REM_W-1:0]   w_rem_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake/status outputs
    always_comb begin
        w_state_nxt = r_state;
        start_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (w_last_bit) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Accepting here chains straight into the next word.
                start_ready = 1'b1;
                done        = 1'b1;
                w_state_nxt = start_valid ? ST_SHIFT : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_accept   = start_valid && start_ready;
    assign w_last_bit = (r_bit_cnt == c_cnt_one);

    // Remainder step: t = 2*rem + bit is always < 2*DIVISOR, so one
    // conditional subtract brings it back into range.
    assign w_t       = {r_rem, r_shift[WIDTH-1]};
    assign w_rem_nxt = (w_t >= c_divisor) ? REM_W'(w_t - c_divisor) : REM_W'(w_t);

`ifdef SERIAL_MOD_REM_OUT_EN
    logic [REM_W-1:0] r_rem_out;
`endif

    // Datapath: shift register, running remainder, bit counter, result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift     <= '0;
            r_rem       <= '0;
            r_bit_cnt   <= '0;
            r_divisible <= 1'b0;
`ifdef SERIAL_MOD_REM_OUT_EN
            r_rem_out   <= '0;
`endif
        end else if (w_accept) begin
            // The previous result is deliberately left standing here.
            r_shift   <= data_in;
            r_rem     <= '0;
            r_bit_cnt <= c_width;
        end else if (r_state == ST_SHIFT) begin
            r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
            r_rem     <= w_rem_nxt;
            r_bit_cnt <= r_bit_cnt - c_cnt_one;
            if (w_last_bit) begin
                r_divisible <= (w_rem_nxt == '0);
`ifdef SERIAL_MOD_REM_OUT_EN
                r_rem_out   <= w_rem_nxt;
`endif
            end
        end
    end

    assign bit_cnt    = r_bit_cnt;
    assign divisible  = r_divisible;
    assign serial_bit = r_shift[WIDTH-1];
`ifdef SERIAL_MOD_REM_OUT_EN
    assign remainder_out = r_rem_out;
`endif

endmodule

`default_nettype wire
